jtvigil_objdraw: RTL and testbench



---
 rtl/jtvigil_objdraw_pkg.sv | 29 ++
 rtl/jtvigil_objdraw_if.sv | 27 ++
 rtl/jtvigil_objdraw_lbuf.sv | 44 ++++
 rtl/jtvigil_objdraw.sv | 148 ++++++++++++++
 tb/tb_jtvigil_objdraw.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtvigil_objdraw_pkg.sv
// Shared constants, FSM encoding and the planar pixel extraction used by the
// Vigilante object drawer and its scanner.
package jtvigil_objdraw_pkg;

  localparam int WORD_W   = 32;
  localparam int SPRITE_W = 16;
  localparam int CODE_W   = 13;
  localparam int VSUB_W   = 4;
  localparam int PAL_W    = 4;
  localparam int COL_W    = 9;
  localparam int ADDR_W   = 18;
  localparam int PXL_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAW  = 2'd2
  } obj_state_e;

  // Pixel n (0 = leftmost) of a planar word; hflip mirrors the order in the word.
  function automatic logic [3:0] obj_pixel(input logic [WORD_W-1:0] d,
                                           input logic [2:0]        n,
                                           input logic              hflip);
    logic [2:0] m;
    m = hflip ? n : ~n;
    return {d[{2'b11, m}], d[{2'b10, m}], d[{2'b01, m}], d[{2'b00, m}]};
  endfunction

endpackage

// File: rtl/jtvigil_objdraw_if.sv
// Draw request from the object scanner plus the graphics ROM cs/ok handshake.
interface jtvigil_objdraw_if;
  import jtvigil_objdraw_pkg::*;

  logic              draw;
  logic [CODE_W-1:0] code;
  logic [VSUB_W-1:0] vsub;
  logic              hflip;
  logic [PAL_W-1:0]  pal;
  logic [COL_W-1:0]  xpos;
  logic              busy;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_cs;
  logic              rom_ok;
  logic [WORD_W-1:0] rom_data;

  modport master (
    output draw, code, vsub, hflip, pal, xpos, rom_ok, rom_data,
    input  busy, rom_addr, rom_cs
  );

  modport slave (
    input  draw, code, vsub, hflip, pal, xpos, rom_ok, rom_data,
    output busy, rom_addr, rom_cs
  );

endinterface

// File: rtl/jtvigil_objdraw_lbuf.sv
// Ping-pong object line buffer: drawing writes the bank not being read, the
// read port registers the pixel and clears the location on the next clock.
module jtvigil_objdraw_lbuf
  import jtvigil_objdraw_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             bank_i,
  input  logic             wr_en_i,
  input  logic [COL_W-1:0] wr_col_i,
  input  logic [PXL_W-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [COL_W-1:0] rd_col_i,
  output logic [PXL_W-1:0] rd_data_o
);

  logic [PXL_W-1:0] ram_q [0:(2**(COL_W+1))-1];
  logic             clr_q;
  logic [COL_W:0]   clr_addr_q;
  logic [PXL_W-1:0] rd_data_q;

  // Clear and draw always target opposite banks, so ordering here is irrelevant.
  always_ff @(posedge clk) begin
    if (clr_q)   ram_q[clr_addr_q]          <= '0;
    if (wr_en_i) ram_q[{~bank_i, wr_col_i}] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_q      <= 1'b0;
      clr_addr_q <= '0;
      rd_data_q  <= '0;
    end else begin
      clr_q <= rd_en_i;
      if (rd_en_i) begin
        clr_addr_q <= {bank_i, rd_col_i};
        rd_data_q  <= ram_q[{bank_i, rd_col_i}];
      end
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/jtvigil_objdraw.sv
// Object drawer: fetches a 16-pixel 4bpp sprite row as two ROM words and paints
// opaque pixels into the line buffer; the previous line is replayed on pxl_o.
//   state    | meaning
//   ST_IDLE  | waiting for draw
//   ST_FETCH | rom_cs held until rom_ok (first cycle's ok ignored)
//   ST_DRAW  | one pixel per clk, 8 per word
module jtvigil_objdraw
  import jtvigil_objdraw_pkg::*;
#(
  parameter logic [COL_W-1:0] HOFFSET = 9'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pxl_cen_i,
  input  logic             lhbl_i,
  input  logic             flip_i,
  input  logic [COL_W-1:0] h_i,
  jtvigil_objdraw_if.slave obj,
  output logic [PXL_W-1:0] pxl_o
);

  obj_state_e        state_q, state_d;
  logic              half_q, half_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [VSUB_W-1:0] vsub_q, vsub_d;
  logic              hflip_q, hflip_d;
  logic [PAL_W-1:0]  pal_q, pal_d;
  logic [COL_W-1:0]  xpos_q, xpos_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              first_q, first_d;
  logic              lhbl_q;
  logic              bank_q, bank_d;
  logic              hb_fall;

  logic              wr_en;
  logic [COL_W-1:0]  wr_col;
  logic [PXL_W-1:0]  wr_data;
  logic [3:0]        pix;

  assign hb_fall = lhbl_q & ~lhbl_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      half_q  <= 1'b0;
      cnt_q   <= '0;
      code_q  <= '0;
      vsub_q  <= '0;
      hflip_q <= 1'b0;
      pal_q   <= '0;
      xpos_q  <= '0;
      data_q  <= '0;
      first_q <= 1'b0;
      lhbl_q  <= 1'b0;
      bank_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      vsub_q  <= vsub_d;
      hflip_q <= hflip_d;
      pal_q   <= pal_d;
      xpos_q  <= xpos_d;
      data_q  <= data_d;
      first_q <= first_d;
      lhbl_q  <= lhbl_i;
      bank_q  <= bank_d;
    end
  end

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    vsub_d  = vsub_q;
    hflip_d = hflip_q;
    pal_d   = pal_q;
    xpos_d  = xpos_q;
    data_d  = data_q;
    first_d = 1'b0;
    bank_d  = bank_q ^ hb_fall;
    if (hb_fall) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (obj.draw) begin
            code_d  = obj.code;
            vsub_d  = obj.vsub;
            hflip_d = obj.hflip;
            pal_d   = obj.pal;
            xpos_d  = obj.xpos;
            half_d  = 1'b0;
            first_d = 1'b1;
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (obj.rom_ok && !first_q) begin
            data_d  = obj.rom_data;
            cnt_d   = '0;
            state_d = ST_DRAW;
          end
        end
        ST_DRAW: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (!half_q) begin
              half_d  = 1'b1;
              first_d = 1'b1;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    obj.busy     = (state_q != ST_IDLE);
    obj.rom_cs   = (state_q == ST_FETCH);
    obj.rom_addr = {code_q, half_q ^ hflip_q, vsub_q};
    pix          = obj_pixel(data_q, cnt_q, hflip_q);
    wr_col       = xpos_q + HOFFSET + {5'd0, half_q, cnt_q};
    wr_data      = {pal_q, pix};
    // A write landing on the bank-swap edge would hit the bank just exposed for reading.
    wr_en        = (state_q == ST_DRAW) && (pix != 4'd0) && !hb_fall;
  end

  jtvigil_objdraw_lbuf u_lbuf (
    .clk       (clk),
    .rst       (rst),
    .bank_i    (bank_q),
    .wr_en_i   (wr_en),
    .wr_col_i  (wr_col),
    .wr_data_i (wr_data),
    .rd_en_i   (pxl_cen_i),
    .rd_col_i  (h_i ^ {COL_W{flip_i}}),
    .rd_data_o (pxl_o)
  );

endmodule

// File: tb/tb_jtvigil_objdraw.sv
// Bench for jtvigil_objdraw: vector table, hand sequences for handshake/abort,
// and random sprite lines checked against a line-level reference model.
module tb_jtvigil_objdraw;

  logic       clk = 1'b0;
  logic       rst;
  logic       pxl_cen;
  logic       lhbl;
  logic       flip;
  logic [8:0] h;
  logic [7:0] pxl;

  jtvigil_objdraw_if ifc();

  jtvigil_objdraw dut (
    .clk       (clk),
    .rst       (rst),
    .pxl_cen_i (pxl_cen),
    .lhbl_i    (lhbl),
    .flip_i    (flip),
    .h_i       (h),
    .obj       (ifc),
    .pxl_o     (pxl)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] rom_w [2];
  int          rom_lat = 1;
  bit          stale_ok = 1'b0;
  int          cs_age = 0;
  logic [7:0]  mbuf [2][512];
  int          mbank = 0;
  logic [7:0]  line_got [512];

  typedef struct {
    logic [12:0] code;
    logic [3:0]  vsub;
    logic        hf;
    logic [3:0]  pal;
    logic [8:0]  xpos;
    logic [31:0] wl;
    logic [31:0] wr;
    logic [17:0] a0;
    logic [17:0] a1;
    int          probe;
    logic [7:0]  pv;
  } vec_t;

  vec_t vt [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; the ROM model answers after rom_lat cycles of rom_cs.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ifc.rom_cs) cs_age++;
    else cs_age = 0;
    ifc.rom_ok   = stale_ok ? 1'b1 : (ifc.rom_cs && cs_age >= rom_lat);
    ifc.rom_data = ifc.rom_addr[4] ? rom_w[1] : rom_w[0];
  endtask

  // Reference: the 16-pixel row is mirrored as a whole when hflip is set.
  task automatic model_draw(input logic [3:0] pal, input logic [8:0] xpos, input logic hf,
                            input logic [31:0] wl, input logic [31:0] wr, input int npix);
    int s, i, col;
    logic [31:0] w;
    logic [3:0]  pix;
    for (int p = 0; p < npix; p++) begin
      s   = hf ? 15 - p : p;
      w   = (s < 8) ? wl : wr;
      i   = s % 8;
      pix = {w[31-i], w[23-i], w[15-i], w[7-i]};
      col = (int'(xpos) + p) % 512;
      if (pix != 4'd0) mbuf[mbank ^ 1][col] = {pal, pix};
    end
  endtask

  task automatic hblank();
    lhbl = 1'b0;
    tick();
    lhbl = 1'b1;
    tick();
    mbank ^= 1;
  endtask

  task automatic read_line(input logic fl, input bit chk);
    int bad, bh, a;
    logic [7:0] ba, be, e;
    bad = 0; bh = 0; ba = '0; be = '0;
    flip = fl;
    for (int c = 0; c < 512; c++) begin
      a = fl ? (c ^ 511) : c;
      h = 9'(c);
      pxl_cen = 1'b1;
      tick();
      pxl_cen = 1'b0;
      e = mbuf[mbank][a];
      mbuf[mbank][a] = '0;
      line_got[c] = pxl;
      if (chk && pxl !== e) begin
        if (bad == 0) begin bh = c; ba = pxl; be = e; end
        bad++;
      end
      tick();
      if (chk && pxl !== e) begin
        if (bad == 0) begin bh = c; ba = pxl; be = e; end
        bad++;
      end
    end
    if (chk) begin
      n_cmp++;
      if (bad != 0) begin
        n_bad++;
        $display("FAIL line_pxl: %0d bad samples, first h=%0d got %02h expected %02h", bad, bh, ba, be);
      end
    end
  endtask

  task automatic do_draw(input logic [12:0] code, input logic [3:0] vsub, input logic hf,
                         input logic [3:0] pal, input logic [8:0] xpos,
                         input logic [31:0] wl, input logic [31:0] wr,
                         input logic [17:0] ea0, input logic [17:0] ea1);
    logic [17:0] addr [$];
    logic [17:0] last;
    logic        prev_cs;
    int n, unstable, fc;
    rom_w[0] = wl;
    rom_w[1] = wr;
    ifc.code = code; ifc.vsub = vsub; ifc.hflip = hf; ifc.pal = pal; ifc.xpos = xpos;
    ifc.draw = 1'b1;
    tick();
    ifc.draw = 1'b0;
    check("busy_rise", 32'(ifc.busy), 32'd1);
    n = 0; unstable = 0; last = '0; prev_cs = 1'b0;
    while (ifc.busy && n < 400) begin
      if (ifc.rom_cs && !prev_cs) addr.push_back(ifc.rom_addr);
      else if (ifc.rom_cs && ifc.rom_addr != last) unstable++;
      last = ifc.rom_addr;
      prev_cs = ifc.rom_cs;
      n++;
      tick();
    end
    fc = stale_ok ? 2 : (rom_lat < 2 ? 2 : rom_lat);
    check("busy_cycles", 32'(n), 32'(2 * (fc + 8)));
    check("addr_stable", 32'(unstable), 32'd0);
    check("fetch_count", 32'(addr.size()), 32'd2);
    if (addr.size() == 2) begin
      check("addr0", 32'(addr[0]), 32'(ea0));
      check("addr1", 32'(addr[1]), 32'(ea1));
    end
    model_draw(pal, xpos, hf, wl, wr, 16);
  endtask

  initial begin
    logic [12:0] rc;
    logic [3:0]  rv, rp;
    logic        rh;
    logic [8:0]  rx;
    logic [31:0] rw [2];
    int          nspr, cnt;

    vt[0] = '{13'h0001, 4'd3, 1'b0, 4'd5, 9'd16,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 18'h00023, 18'h00033, 16, 8'h5F};
    vt[1] = '{13'h0ABC, 4'd7, 1'b1, 4'hA, 9'd0,   32'h8080_8080, 32'h0000_0000, 18'h15797, 18'h15787, 15, 8'hAF};
    vt[2] = '{13'h1FFF, 4'hF, 1'b0, 4'd3, 9'd505, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18'h3FFEF, 18'h3FFFF, 8,  8'h3F};
    vt[3] = '{13'h0002, 4'd0, 1'b0, 4'd1, 9'd100, 32'hF000_0000, 32'h0000_00FF, 18'h00040, 18'h00050, 102, 8'h18};

    rst = 1'b1; pxl_cen = 1'b0; lhbl = 1'b1; flip = 1'b0; h = '0;
    ifc.draw = 1'b0; ifc.code = '0; ifc.vsub = '0; ifc.hflip = 1'b0; ifc.pal = '0; ifc.xpos = '0;
    ifc.rom_ok = 1'b0; ifc.rom_data = '0;
    rom_w[0] = '0; rom_w[1] = '0;
    repeat (3) tick();
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_cs", 32'(ifc.rom_cs), 32'd0);
    check("rst_addr", 32'(ifc.rom_addr), 32'd0);
    check("rst_pxl", 32'(pxl), 32'd0);
    rst = 1'b0;
    tick();

    // Two unchecked passes leave both banks cleared.
    read_line(1'b0, 1'b0);
    hblank();
    read_line(1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      do_draw(vt[i].code, vt[i].vsub, vt[i].hf, vt[i].pal, vt[i].xpos, vt[i].wl, vt[i].wr, vt[i].a0, vt[i].a1);
      hblank();
      read_line(1'b0, 1'b1);
      check($sformatf("vec%0d_probe", i), 32'(line_got[vt[i].probe]), 32'(vt[i].pv));
      if (i == 0) begin
        check("basic_left_edge", 32'(line_got[15]), 32'h0);
        check("basic_right_edge", 32'(line_got[32]), 32'h0);
        hblank();
        read_line(1'b0, 1'b1);
        hblank();
        read_line(1'b0, 1'b1);
        check("clear_two_lines", 32'(line_got[16]), 32'h0);
      end
    end

    // Overlap: second sprite transparent on the left half.
    do_draw(13'h0010, 4'd1, 1'b0, 4'd2, 9'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18'h00201, 18'h00211);
    do_draw(13'h0011, 4'd1, 1'b0, 4'd7, 9'd0, 32'h0000_0000, 32'hFFFF_FFFF, 18'h00221, 18'h00231);
    hblank();
    read_line(1'b0, 1'b1);
    check("overlap_keep", 32'(line_got[3]), 32'h2F);
    check("overlap_over", 32'(line_got[12]), 32'h7F);

    // Flip: column 0 shows up at h=511.
    do_draw(13'h0020, 4'd2, 1'b0, 4'd4, 9'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 18'h00402, 18'h00412);
    hblank();
    read_line(1'b1, 1'b1);
    check("flip_h511", 32'(line_got[511]), 32'h4F);

    // Stale ok: rom_ok high all along must still cost two fetch cycles.
    stale_ok = 1'b1;
    do_draw(13'h0030, 4'd5, 1'b1, 4'd6, 9'd200, 32'h1234_5678, 32'h9ABC_DEF0, 18'h00615, 18'h00605);
    stale_ok = 1'b0;
    hblank();
    read_line(1'b0, 1'b1);

    // Abort in the first fetch: nothing written.
    rom_lat = 6;
    rom_w[0] = 32'hFFFF_FFFF; rom_w[1] = 32'hFFFF_FFFF;
    ifc.code = 13'h0040; ifc.vsub = '0; ifc.hflip = 1'b0; ifc.pal = 4'd9; ifc.xpos = 9'd50;
    ifc.draw = 1'b1;
    tick();
    ifc.draw = 1'b0;
    tick();
    lhbl = 1'b0;
    tick();
    check("abort_cs", 32'(ifc.rom_cs), 32'd0);
    check("abort_busy", 32'(ifc.busy), 32'd0);
    lhbl = 1'b1;
    tick();
    mbank ^= 1;
    read_line(1'b0, 1'b1);

    // Abort in the second fetch: only the left half is written.
    ifc.draw = 1'b1;
    tick();
    ifc.draw = 1'b0;
    cnt = 0;
    for (int k = 0; k < 100 && cnt < 2; k++) begin
      if (ifc.rom_cs && cs_age == 1) cnt++;
      if (cnt < 2) tick();
    end
    check("second_fetch_seen", 32'(cnt), 32'd2);
    tick();
    lhbl = 1'b0;
    tick();
    check("abort2_busy", 32'(ifc.busy), 32'd0);
    model_draw(4'd9, 9'd50, 1'b0, rom_w[0], rom_w[1], 8);
    lhbl = 1'b1;
    tick();
    mbank ^= 1;
    read_line(1'b0, 1'b1);
    rom_lat = 1;

    // draw coinciding with the LHBL fall is ignored.
    lhbl = 1'b0;
    ifc.draw = 1'b1;
    tick();
    ifc.draw = 1'b0;
    check("draw_on_fall", 32'(ifc.busy), 32'd0);
    lhbl = 1'b1;
    tick();
    mbank ^= 1;

    for (int ln = 0; ln < 6; ln++) begin
      nspr = $urandom_range(1, 4);
      rom_lat = $urandom_range(1, 4);
      for (int s = 0; s < nspr; s++) begin
        rc = 13'($urandom_range(0, 8191));
        rv = 4'($urandom_range(0, 15));
        rh = 1'($urandom_range(0, 1));
        rp = 4'($urandom_range(0, 15));
        rx = 9'($urandom_range(0, 511));
        for (int k = 0; k < 2; k++) begin
          case ($urandom_range(0, 3))
            0: rw[k] = 32'h0;
            1: rw[k] = $urandom;
            2: rw[k] = $urandom & $urandom;
            default: rw[k] = 32'hFFFF_FFFF;
          endcase
        end
        do_draw(rc, rv, rh, rp, rx, rw[0], rw[1],
                18'(int'(rc) * 32 + (rh ? 16 : 0) + int'(rv)),
                18'(int'(rc) * 32 + (rh ? 0 : 16) + int'(rv)));
      end
      hblank();
      read_line(1'($urandom_range(0, 1)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
